// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bus bundle for mem_port_arbiter.
// The arbiter binds to the slave modport; requesters and the memory model use master.
interface mem_port_arbiter_if;
  logic        REQ0, REQ1;
  logic        WE0, WE1;
  logic [15:0] ADDR0, ADDR1;
  logic [15:0] WD0, WD1;
  logic        ACK0, ACK1;
  logic [15:0] RDATA;
  logic [15:0] MA;
  logic [15:0] MWD;
  logic        MWE;
  logic [15:0] MRD;
  logic        BUSY;
  logic        OWNER;

  modport slave (
    input  REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WD0, WD1, MRD,
    output ACK0, ACK1, RDATA, MA, MWD, MWE, BUSY, OWNER
  );

  modport master (
    output REQ0, REQ1, WE0, WE1, ADDR0, ADDR1, WD0, WD1, MRD,
    input  ACK0, ACK1, RDATA, MA, MWD, MWE, BUSY, OWNER
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing a single-port 16-bit memory between two requesters.
// Serialises accesses, sequences memory read latency and returns a one-cycle ACK.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input logic           CK,
  input logic           RST,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CW-1:0] LAT_LOAD = (MEM_LAT >= 2) ? CW'(MEM_LAT - 2) : '0;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [DW-1:0] ma_q, ma_d;
  logic [DW-1:0] mwd_q, mwd_d;
  logic          mwe_q, mwe_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          win;

  always_ff @(posedge CK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      ctr_q   <= '0;
      owner_q <= 1'b1;
      we_q    <= 1'b0;
      ma_q    <= '0;
      mwd_q   <= '0;
      mwe_q   <= 1'b0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      ma_q    <= ma_d;
      mwd_q   <= mwd_d;
      mwe_q   <= mwe_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= busy_d;
    end
  end

  // Outputs are computed from the next state so every pin comes straight off a flop.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    owner_d = owner_q;
    we_d    = we_q;
    ma_d    = ma_q;
    mwd_d   = mwd_q;
    mwe_d   = 1'b0;
    rdata_d = rdata_q;
    win     = owner_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ0 | bus.REQ1) begin
          // On a tie the requester not served last wins.
          win     = (bus.REQ0 & bus.REQ1) ? ~owner_q : bus.REQ1;
          owner_d = win;
          we_d    = win ? bus.WE1 : bus.WE0;
          ma_d    = win ? bus.ADDR1 : bus.ADDR0;
          if (we_d) mwd_d = win ? bus.WD1 : bus.WD0;
          mwe_d   = we_d;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else if (MEM_LAT <= 1) begin
          rdata_d = bus.MRD;
          state_d = S_DONE;
        end else begin
          ctr_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ctr_q == '0) begin
          rdata_d = bus.MRD;
          state_d = S_DONE;
        end else begin
          ctr_d = ctr_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack0_d = (state_d == S_DONE) & ~owner_d;
    ack1_d = (state_d == S_DONE) &  owner_d;
    busy_d = (state_d != S_IDLE);
  end

  assign bus.ACK0  = ack0_q;
  assign bus.ACK1  = ack1_q;
  assign bus.RDATA = rdata_q;
  assign bus.MA    = ma_q;
  assign bus.MWD   = mwd_q;
  assign bus.MWE   = mwe_q;
  assign bus.BUSY  = busy_q;
  assign bus.OWNER = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1 with a RAM model,
// one at MEM_LAT=3 with a pipelined ROM model.
module tb_mem_port_arbiter;

  logic CK;
  logic RST;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if if_a ();
  mem_port_arbiter_if if_b ();

  mem_port_arbiter #(.MEM_LAT(1)) dut_a (.CK(CK), .RST(RST), .bus(if_a));
  mem_port_arbiter #(.MEM_LAT(3)) dut_b (.CK(CK), .RST(RST), .bus(if_b));

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  // RAM behind dut_a: combinational read (one-cycle latency from registered MA).
  logic [15:0] mem_a [0:255];
  always @(posedge CK) begin
    if (if_a.MWE) mem_a[if_a.MA[7:0]] <= if_a.MWD;
  end
  assign if_a.MRD = mem_a[if_a.MA[7:0]];

  // ROM behind dut_b: two pipeline stages so data is valid three cycles after MA.
  function automatic logic [15:0] rom(input logic [15:0] a);
    return (a == 16'h0100) ? 16'h1234 : ~a;
  endfunction
  logic [15:0] rp1, rp2;
  always @(posedge CK) begin
    rp1 <= rom(if_b.MA);
    rp2 <= rp1;
  end
  assign if_b.MRD = rp2;

  task automatic idle_inputs();
    if_a.REQ0 = 0; if_a.REQ1 = 0; if_a.WE0 = 0; if_a.WE1 = 0;
    if_a.ADDR0 = 0; if_a.ADDR1 = 0; if_a.WD0 = 0; if_a.WD1 = 0;
    if_b.REQ0 = 0; if_b.REQ1 = 0; if_b.WE0 = 0; if_b.WE1 = 0;
    if_b.ADDR0 = 0; if_b.ADDR1 = 0; if_b.WD0 = 0; if_b.WD1 = 0;
  endtask

  // Stimulus only: issue one request on dut_a from IDLE and report ACK cycle and MWE cycles.
  task automatic access_a(input bit idx, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, output int ack_c, output int mwe_n);
    ack_c = -1;
    mwe_n = 0;
    if (idx) begin
      if_a.REQ1 = 1; if_a.WE1 = we; if_a.ADDR1 = addr; if_a.WD1 = wd;
    end else begin
      if_a.REQ0 = 1; if_a.WE0 = we; if_a.ADDR0 = addr; if_a.WD0 = wd;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge CK);
      if (if_a.MWE) mwe_n++;
      if ((idx ? if_a.ACK1 : if_a.ACK0) === 1'b1) begin
        ack_c = c;
        break;
      end
    end
    if_a.REQ0 = 0;
    if_a.REQ1 = 0;
    @(negedge CK);
  endtask

  task automatic test_reset();
    RST = 0;
    repeat (2) @(negedge CK);
    RST = 1;
    @(negedge CK);
    n_checks++; if (if_a.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", if_a.BUSY); end
    n_checks++; if (if_a.OWNER !== 1'b1) begin n_fail++; $display("FAIL rst_owner: got %b expected 1", if_a.OWNER); end
    n_checks++; if ({if_a.ACK0, if_a.ACK1, if_a.MWE} !== 3'b000) begin n_fail++; $display("FAIL rst_ack_mwe: got %b expected 000", {if_a.ACK0, if_a.ACK1, if_a.MWE}); end
    n_checks++; if ({if_a.MA, if_a.MWD, if_a.RDATA} !== 48'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", {if_a.MA, if_a.MWD, if_a.RDATA}); end
    n_checks++; if (if_b.OWNER !== 1'b1) begin n_fail++; $display("FAIL rst_owner_b: got %b expected 1", if_b.OWNER); end
    // Reset in the middle of a write ACCESS cycle.
    if_a.REQ0 = 1; if_a.WE0 = 1; if_a.ADDR0 = 16'h0040; if_a.WD0 = 16'hAAAA;
    @(negedge CK);
    n_checks++; if (if_a.MWE !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mwe: got %b expected 1", if_a.MWE); end
    #2 RST = 0;
    #1;
    n_checks++; if (if_a.MWE !== 1'b0) begin n_fail++; $display("FAIL rst_async_mwe: got %b expected 0", if_a.MWE); end
    n_checks++; if (if_a.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b expected 0", if_a.BUSY); end
    if_a.REQ0 = 0;
    @(negedge CK);
    RST = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CK);
      n_checks++; if ({if_a.ACK0, if_a.ACK1, if_a.BUSY} !== 3'b000) begin n_fail++; $display("FAIL rst_after_idle c%0d: got %b expected 000", c, {if_a.ACK0, if_a.ACK1, if_a.BUSY}); end
    end
    n_checks++; if (if_a.OWNER !== 1'b1) begin n_fail++; $display("FAIL rst_after_owner: got %b expected 1", if_a.OWNER); end
  endtask

  task automatic test_write_read();
    int ack_c, mwe_n;
    if_a.REQ0 = 1; if_a.WE0 = 1; if_a.ADDR0 = 16'h0010; if_a.WD0 = 16'hBEEF;
    @(negedge CK);
    n_checks++; if ({if_a.MWE, if_a.MA, if_a.MWD} !== {1'b1, 16'h0010, 16'hBEEF}) begin n_fail++; $display("FAIL wr_access: got %b %h %h expected 1 0010 beef", if_a.MWE, if_a.MA, if_a.MWD); end
    @(negedge CK);
    n_checks++; if ({if_a.ACK0, if_a.ACK1, if_a.MWE} !== 3'b100) begin n_fail++; $display("FAIL wr_ack_e2: got %b expected 100", {if_a.ACK0, if_a.ACK1, if_a.MWE}); end
    if_a.REQ0 = 0;
    @(negedge CK);
    n_checks++; if (mem_a[8'h10] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem: got %h expected beef", mem_a[8'h10]); end
    access_a(1'b0, 1'b0, 16'h0010, 16'h0000, ack_c, mwe_n);
    n_checks++; if (ack_c !== 2) begin n_fail++; $display("FAIL rd_ack_cycle: got %0d expected 2", ack_c); end
    n_checks++; if (mwe_n !== 0) begin n_fail++; $display("FAIL rd_mwe: got %0d expected 0", mwe_n); end
    n_checks++; if (if_a.RDATA !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected beef", if_a.RDATA); end
  endtask

  task automatic test_lat3();
    int ack_c;
    ack_c = -1;
    if_b.REQ1 = 1; if_b.WE1 = 0; if_b.ADDR1 = 16'h0100;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CK);
      if (c <= 3) begin
        n_checks++; if ({if_b.MA, if_b.MWE, if_b.ACK1} !== {16'h0100, 2'b00}) begin n_fail++; $display("FAIL lat3_hold c%0d: got %h %b %b expected 0100 0 0", c, if_b.MA, if_b.MWE, if_b.ACK1); end
      end
      if (if_b.ACK1 === 1'b1) begin ack_c = c; break; end
    end
    n_checks++; if (ack_c !== 4) begin n_fail++; $display("FAIL lat3_ack_cycle: got %0d expected 4", ack_c); end
    n_checks++; if (if_b.RDATA !== 16'h1234) begin n_fail++; $display("FAIL lat3_rdata: got %h expected 1234", if_b.RDATA); end
    n_checks++; if (if_b.ACK0 !== 1'b0) begin n_fail++; $display("FAIL lat3_ack0: got %b expected 0", if_b.ACK0); end
    if_b.REQ1 = 0;
    @(negedge CK);
  endtask

  task automatic test_tie();
    int seq [2];
    int cyc [2];
    int n;
    n = 0;
    RST = 0;
    @(negedge CK);
    RST = 1;
    @(negedge CK);
    if_a.REQ0 = 1; if_a.WE0 = 1; if_a.ADDR0 = 16'h0020; if_a.WD0 = 16'h1111;
    if_a.REQ1 = 1; if_a.WE1 = 1; if_a.ADDR1 = 16'h0020; if_a.WD1 = 16'h2222;
    for (int c = 1; c <= 20 && n < 2; c++) begin
      @(negedge CK);
      if (if_a.ACK0 === 1'b1) begin seq[n] = 0; cyc[n] = c; n++; if_a.REQ0 = 0; end
      else if (if_a.ACK1 === 1'b1) begin seq[n] = 1; cyc[n] = c; n++; if_a.REQ1 = 0; end
    end
    if_a.REQ0 = 0; if_a.REQ1 = 0;
    @(negedge CK);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL tie_count: got %0d expected 2", n); end
    else begin
      n_checks++; if ({seq[0], seq[1]} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL tie_order: got %0d,%0d expected 0,1", seq[0], seq[1]); end
      n_checks++; if ({cyc[0], cyc[1]} !== {32'd2, 32'd5}) begin n_fail++; $display("FAIL tie_cycles: got %0d,%0d expected 2,5", cyc[0], cyc[1]); end
    end
    n_checks++; if (mem_a[8'h20] !== 16'h2222) begin n_fail++; $display("FAIL tie_mem: got %h expected 2222", mem_a[8'h20]); end
    n_checks++; if (if_a.OWNER !== 1'b1) begin n_fail++; $display("FAIL tie_owner: got %b expected 1", if_a.OWNER); end
  endtask

  task automatic test_fairness();
    int seq [4];
    int cyc [4];
    int n;
    n = 0;
    if_a.REQ0 = 1; if_a.WE0 = 1; if_a.ADDR0 = 16'h0050; if_a.WD0 = 16'h0A0A;
    if_a.REQ1 = 1; if_a.WE1 = 1; if_a.ADDR1 = 16'h0051; if_a.WD1 = 16'h0B0B;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CK);
      if (n < 4 && if_a.ACK0 === 1'b1) begin seq[n] = 0; cyc[n] = c; n++; end
      else if (n < 4 && if_a.ACK1 === 1'b1) begin seq[n] = 1; cyc[n] = c; n++; end
    end
    if_a.REQ0 = 0; if_a.REQ1 = 0;
    repeat (2) @(negedge CK);
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL fair_count: got %0d expected 4", n); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++; if (seq[i] !== (i % 2) || cyc[i] !== 2 + 3 * i) begin n_fail++; $display("FAIL fair_grant%0d: got req%0d at c%0d expected req%0d at c%0d", i, seq[i], cyc[i], i % 2, 2 + 3 * i); end
      end
    end
    n_checks++; if (mem_a[8'h51] !== 16'h0B0B) begin n_fail++; $display("FAIL fair_mem1: got %h expected 0b0b", mem_a[8'h51]); end
  endtask

  task automatic test_stale();
    int ack_c, mwe_n;
    access_a(1'b0, 1'b0, 16'h0010, 16'h0000, ack_c, mwe_n);
    n_checks++; if (if_a.RDATA !== 16'hBEEF) begin n_fail++; $display("FAIL stale_pre_rdata: got %h expected beef", if_a.RDATA); end
    if_a.REQ0 = 1; if_a.WE0 = 1; if_a.ADDR0 = 16'h0030; if_a.WD0 = 16'h5555;
    repeat (2) @(negedge CK);
    n_checks++; if (if_a.ACK0 !== 1'b1) begin n_fail++; $display("FAIL stale_ack: got %b expected 1", if_a.ACK0); end
    @(negedge CK);
    n_checks++; if ({if_a.BUSY, if_a.ACK0, if_a.MWE} !== 3'b000) begin n_fail++; $display("FAIL stale_idle: got %b expected 000", {if_a.BUSY, if_a.ACK0, if_a.MWE}); end
    n_checks++; if (if_a.RDATA !== 16'hBEEF) begin n_fail++; $display("FAIL stale_wr_rdata: got %h expected beef", if_a.RDATA); end
    @(negedge CK);
    n_checks++; if ({if_a.BUSY, if_a.MWE, if_a.MA} !== {2'b11, 16'h0030}) begin n_fail++; $display("FAIL stale_restart: got %b %b %h expected 1 1 0030", if_a.BUSY, if_a.MWE, if_a.MA); end
    @(negedge CK);
    n_checks++; if (if_a.ACK0 !== 1'b1) begin n_fail++; $display("FAIL stale_ack2: got %b expected 1", if_a.ACK0); end
    if_a.REQ0 = 0;
    @(negedge CK);
    n_checks++; if (mem_a[8'h30] !== 16'h5555) begin n_fail++; $display("FAIL stale_mem: got %h expected 5555", mem_a[8'h30]); end
    n_checks++; if (if_a.RDATA !== 16'hBEEF) begin n_fail++; $display("FAIL stale_end_rdata: got %h expected beef", if_a.RDATA); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 0;
    idle_inputs();
    test_reset();
    test_write_read();
    test_lat3();
    test_tie();
    test_fairness();
    test_stale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
